// File: rtl/rv_ex_stage_md.sv
// rv_ex_stage_md: RV32/64 execute stage with EX/MEM register and optional multi-cycle RV-M unit.
// Define RV_EX_MULDIV_EN to build the multiply/divide FSM; otherwise M ops retire as harmless bubbles.
module rv_ex_stage_md #(
    parameter int XLEN          = 32,
    parameter int DIV_STEP_BITS = 1
) (
    input  logic            i_exm_clk,
    input  logic            i_exm_rstn,
    input  logic            i_exm_valid,
    input  logic            i_exm_kill,
    input  logic [XLEN-1:0] i_exm_pc,
    input  logic [XLEN-1:0] i_exm_rs1,
    input  logic [XLEN-1:0] i_exm_rs2,
    input  logic [XLEN-1:0] i_exm_ext_imm,
    input  logic [3:0]      i_exm_alu_ctrl,
    input  logic            i_exm_alu_a_sel,
    input  logic            i_exm_alu_b_sel,
    input  logic            i_exm_is_md,
    input  logic [2:0]      i_exm_md_func3,
    input  logic [4:0]      i_exm_rf_wa,
    input  logic            i_exm_rf_we,
    output logic            o_exm_stall,
    output logic            o_exm_mem_valid,
    output logic [XLEN-1:0] o_exm_mem_res,
    output logic [4:0]      o_exm_mem_rf_wa,
    output logic            o_exm_mem_rf_we
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] w_a, w_b, w_alu, w_md_res, w_res;
    logic [SW-1:0]   w_sh;
    logic            w_stall, w_md_ok, w_fin, w_we;

    always_comb begin
        w_a  = i_exm_alu_a_sel ? i_exm_pc : i_exm_rs1;
        w_b  = i_exm_alu_b_sel ? i_exm_rs2 : i_exm_ext_imm;
        w_sh = w_b[SW-1:0];
        case (i_exm_alu_ctrl)
            4'd0:    w_alu = w_a + w_b;
            4'd1:    w_alu = w_a - w_b;
            4'd2:    w_alu = w_a << w_sh;
            4'd3:    w_alu = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            4'd4:    w_alu = {{(XLEN-1){1'b0}}, w_a < w_b};
            4'd5:    w_alu = w_a ^ w_b;
            4'd6:    w_alu = w_a >> w_sh;
            4'd7:    w_alu = $signed(w_a) >>> w_sh;
            4'd8:    w_alu = w_a | w_b;
            4'd9:    w_alu = w_a & w_b;
            4'd10:   w_alu = w_b;
            default: w_alu = '0;
        endcase
    end

`ifdef RV_EX_MULDIV_EN
    localparam int NSTEP = XLEN / DIV_STEP_BITS;
    localparam int CW    = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              r_state, w_next;
    // r_quo/r_rem double as the low/high product halves after MUL
    logic [XLEN-1:0]     r_quo, r_rem, r_dvs, w_q, w_r, w_m1, w_m2;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_func3;
    logic                r_negq, r_negr, w_sgn, w_div0, w_ovf;
    logic [XLEN:0]       w_t;
    logic signed [XLEN:0]     w_pa, w_pb;
    logic signed [2*XLEN-1:0] w_prod;

    assign w_sgn  = !i_exm_md_func3[0];
    assign w_div0 = i_exm_rs2 == '0;
    assign w_ovf  = w_sgn & (i_exm_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_exm_rs2);
    assign w_m1   = (w_sgn & i_exm_rs1[XLEN-1]) ? -i_exm_rs1 : i_exm_rs1;
    assign w_m2   = (w_sgn & i_exm_rs2[XLEN-1]) ? -i_exm_rs2 : i_exm_rs2;
    assign w_pa   = {(r_func3 == 3'd1 || r_func3 == 3'd2) & r_quo[XLEN-1], r_quo};
    assign w_pb   = {(r_func3 == 3'd1) & r_dvs[XLEN-1], r_dvs};
    assign w_prod = (2*XLEN)'(w_pa) * (2*XLEN)'(w_pb);

    always_comb begin
        w_q = r_quo;
        w_r = r_rem;
        w_t = '0;
        for (int k = 0; k < DIV_STEP_BITS; k++) begin
            w_t = {w_r, w_q[XLEN-1]};
            w_q = {w_q[XLEN-2:0], 1'b0};
            if (w_t >= {1'b0, r_dvs}) begin
                w_t    = w_t - {1'b0, r_dvs};
                w_q[0] = 1'b1;
            end
            w_r = w_t[XLEN-1:0];
        end
    end

    always_comb begin
        w_next  = S_IDLE;
        w_stall = 1'b0;
        if (!i_exm_kill) begin
            case (r_state)
                S_IDLE: if (i_exm_valid & i_exm_is_md) begin
                    w_stall = 1'b1;
                    w_next  = !i_exm_md_func3[2] ? S_MUL : (w_div0 | w_ovf) ? S_DONE : S_DIV;
                end
                S_MUL: begin
                    w_stall = 1'b1;
                    w_next  = S_DONE;
                end
                S_DIV: begin
                    w_stall = 1'b1;
                    w_next  = (r_cnt == CW'(1)) ? S_DONE : S_DIV;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_exm_clk or negedge i_exm_rstn) begin
        if (!i_exm_rstn) begin
            r_state <= S_IDLE;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_func3 <= '0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_stall) begin
                r_func3 <= i_exm_md_func3;
                r_cnt   <= CW'(NSTEP);
                r_negq  <= 1'b0;
                r_negr  <= 1'b0;
                r_dvs   <= i_exm_rs2;
                r_rem   <= '0;
                r_quo   <= i_exm_rs1;
                if (i_exm_md_func3[2] && w_div0) begin
                    r_quo <= '1;
                    r_rem <= i_exm_rs1;
                end else if (i_exm_md_func3[2] && !w_ovf) begin
                    r_quo  <= w_m1;
                    r_dvs  <= w_m2;
                    r_negq <= w_sgn & (i_exm_rs1[XLEN-1] ^ i_exm_rs2[XLEN-1]);
                    r_negr <= w_sgn & i_exm_rs1[XLEN-1];
                end
            end else if (r_state == S_MUL) begin
                {r_rem, r_quo} <= w_prod;
            end else if (r_state == S_DIV && !i_exm_kill) begin
                r_quo <= w_q;
                r_rem <= w_r;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign w_md_ok  = r_state == S_DONE;
    assign w_md_res = !r_func3[2] ? ((r_func3[1:0] == 2'd0) ? r_quo : r_rem) :
                      r_func3[1]  ? (r_negr ? -r_rem : r_rem) : (r_negq ? -r_quo : r_quo);
`else
    logic w_unused;
    assign w_unused = ^i_exm_md_func3;
    assign w_stall  = 1'b0;
    assign w_md_ok  = 1'b0;
    assign w_md_res = '0;
`endif

    assign o_exm_stall = w_stall & i_exm_rstn;
    assign w_fin       = i_exm_valid & !i_exm_kill & !w_stall;
    assign w_res       = i_exm_is_md ? w_md_res : w_alu;
    assign w_we        = i_exm_rf_we & (!i_exm_is_md | w_md_ok);

    always_ff @(posedge i_exm_clk or negedge i_exm_rstn) begin
        if (!i_exm_rstn) begin
            o_exm_mem_valid <= 1'b0;
            o_exm_mem_res   <= '0;
            o_exm_mem_rf_wa <= '0;
            o_exm_mem_rf_we <= 1'b0;
        end else if (w_fin) begin
            o_exm_mem_valid <= 1'b1;
            o_exm_mem_res   <= w_res;
            o_exm_mem_rf_wa <= i_exm_rf_wa;
            o_exm_mem_rf_we <= w_we;
        end else begin
            o_exm_mem_valid <= 1'b0;
            o_exm_mem_rf_wa <= '0;
            o_exm_mem_rf_we <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rv_ex_stage_md.sv
// tb_rv_ex_stage_md: vector table plus kill/reset sequences for rv_ex_stage_md (XLEN=32, 1 quotient bit per cycle).
// Writebacks are matched against a queue of expected results.
module tb_rv_ex_stage_md;
    localparam int XLEN = 32;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                           A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9, A_PB = 4'd10;

    logic            clk = 1'b0, rstn = 1'b1, valid = 1'b0, kill = 1'b0;
    logic            asel = 1'b0, bsel = 1'b0, is_md = 1'b0, we = 1'b0;
    logic [XLEN-1:0] pc = '0, rs1 = '0, rs2 = '0, imm = '0;
    logic [3:0]      alu = '0;
    logic [2:0]      f3 = '0;
    logic [4:0]      wa = '0;
    logic            stall, mvalid, mwe;
    logic [XLEN-1:0] mres;
    logic [4:0]      mwa;

    always #5 clk = ~clk;

    rv_ex_stage_md #(.XLEN(XLEN), .DIV_STEP_BITS(1)) dut (
        .i_exm_clk(clk), .i_exm_rstn(rstn), .i_exm_valid(valid), .i_exm_kill(kill),
        .i_exm_pc(pc), .i_exm_rs1(rs1), .i_exm_rs2(rs2), .i_exm_ext_imm(imm),
        .i_exm_alu_ctrl(alu), .i_exm_alu_a_sel(asel), .i_exm_alu_b_sel(bsel),
        .i_exm_is_md(is_md), .i_exm_md_func3(f3), .i_exm_rf_wa(wa), .i_exm_rf_we(we),
        .o_exm_stall(stall), .o_exm_mem_valid(mvalid), .o_exm_mem_res(mres),
        .o_exm_mem_rf_wa(mwa), .o_exm_mem_rf_we(mwe)
    );

    typedef struct {
        logic        md;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        asel, bsel, we;
        logic [31:0] pc, rs1, rs2, imm, res;
        int          stl;
    } vec_t;
    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
    } exp_t;

    vec_t tv[$];
    exp_t sb[$];
    exp_t e_mon;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            if (sb.size() == 0) chk("unexpected_wb", mvalid, 1'b0);
            else begin
                e_mon = sb.pop_front();
                chk("wb_res", mres, e_mon.res);
                chk("wb_wa", mwa, e_mon.wa);
                chk("wb_we", mwe, e_mon.we);
            end
        end
    end

    task automatic drive(input vec_t v, input logic [4:0] dwa);
        valid = 1'b1; is_md = v.md; f3 = v.f3; alu = v.alu; asel = v.asel; bsel = v.bsel;
        we = v.we; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; wa = dwa;
    endtask

    task automatic run_op(input vec_t v, input logic [4:0] dwa);
        exp_t e;
        int   st, est;
        @(posedge clk); #1;
        drive(v, dwa);
`ifdef RV_EX_MULDIV_EN
        e.res = v.res; e.we = v.we; est = v.stl;
`else
        e.res = v.md ? '0 : v.res; e.we = v.we & !v.md; est = v.md ? 0 : v.stl;
`endif
        e.wa = dwa;
        sb.push_back(e);
        st = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            st++;
        end
        chk("stall_cycles", st, est);
        @(posedge clk); #1;
        chk("wb_latency", mvalid, 1'b1);
        valid = 1'b0; is_md = 1'b0;
    endtask

    function automatic vec_t mk(input logic md, input logic [2:0] fn, input logic [3:0] op,
                                input logic as, input logic bs, input logic w,
                                input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] im, input logic [31:0] r, input int s);
        vec_t v;
        v.md = md; v.f3 = fn; v.alu = op; v.asel = as; v.bsel = bs; v.we = w;
        v.pc = p; v.rs1 = a; v.rs2 = b; v.imm = im; v.res = r; v.stl = s;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t add1, dv;
        tv.push_back(mk(0, 0, A_ADD,  0, 1, 1, 0,       5,            7,            0,            32'd12,       0));
        tv.push_back(mk(0, 0, A_SUB,  0, 1, 1, 0,       5,            7,            0,            32'hFFFFFFFE, 0));
        tv.push_back(mk(0, 0, A_ADD,  0, 0, 1, 0,       100,          0,            32'hFFFFFFFF, 32'd99,       0));
        tv.push_back(mk(0, 0, A_ADD,  1, 0, 1, 32'h1000, 0,           0,            32'h10,       32'h1010,     0));
        tv.push_back(mk(0, 0, A_SLT,  0, 1, 1, 0,       32'hFFFFFFFF, 1,            0,            32'd1,        0));
        tv.push_back(mk(0, 0, A_SLTU, 0, 1, 1, 0,       32'hFFFFFFFF, 1,            0,            32'd0,        0));
        tv.push_back(mk(0, 0, A_SRA,  0, 1, 1, 0,       32'h80000000, 4,            0,            32'hF8000000, 0));
        tv.push_back(mk(0, 0, A_SRL,  0, 1, 1, 0,       32'h80000000, 4,            0,            32'h08000000, 0));
        tv.push_back(mk(0, 0, A_XOR,  0, 1, 1, 0,       32'hF0F0,     32'hFF00,     0,            32'h0FF0,     0));
        tv.push_back(mk(0, 0, A_OR,   0, 1, 1, 0,       32'hF0F0,     32'hFF00,     0,            32'hFFF0,     0));
        tv.push_back(mk(0, 0, A_AND,  0, 1, 1, 0,       32'hF0F0,     32'hFF00,     0,            32'hF000,     0));
        tv.push_back(mk(0, 0, A_SLL,  0, 1, 1, 0,       1,            31,           0,            32'h80000000, 0));
        tv.push_back(mk(0, 0, A_PB,   0, 0, 1, 0,       32'hDEAD,     0,            32'h12345000, 32'h12345000, 0));
        tv.push_back(mk(0, 0, A_ADD,  0, 1, 0, 0,       3,            4,            0,            32'd7,        0));
        tv.push_back(mk(1, 0, A_ADD,  0, 1, 1, 0,       7,            32'hFFFFFFFD, 0,            32'hFFFFFFEB, 2));
        tv.push_back(mk(1, 1, A_ADD,  0, 1, 1, 0,       32'h80000000, 32'h80000000, 0,            32'h40000000, 2));
        tv.push_back(mk(1, 2, A_ADD,  0, 1, 1, 0,       32'hFFFFFFFF, 32'hFFFFFFFF, 0,            32'hFFFFFFFF, 2));
        tv.push_back(mk(1, 3, A_ADD,  0, 1, 1, 0,       32'hFFFFFFFF, 32'hFFFFFFFF, 0,            32'hFFFFFFFE, 2));
        tv.push_back(mk(1, 4, A_ADD,  0, 1, 1, 0,       32'hFFFFFFF9, 2,            0,            32'hFFFFFFFD, 33));
        tv.push_back(mk(1, 6, A_ADD,  0, 1, 1, 0,       32'hFFFFFFF9, 2,            0,            32'hFFFFFFFF, 33));
        tv.push_back(mk(1, 5, A_ADD,  0, 1, 1, 0,       9,            0,            0,            32'hFFFFFFFF, 1));
        tv.push_back(mk(1, 6, A_ADD,  0, 1, 1, 0,       32'h80000000, 32'hFFFFFFFF, 0,            32'h0,        1));
        tv.push_back(mk(1, 4, A_ADD,  0, 1, 1, 0,       32'h80000000, 32'hFFFFFFFF, 0,            32'h80000000, 1));
        tv.push_back(mk(1, 7, A_ADD,  0, 1, 1, 0,       100,          7,            0,            32'd2,        33));
        tv.push_back(mk(1, 6, A_ADD,  0, 1, 1, 0,       7,            0,            0,            32'd7,        1));
        tv.push_back(mk(1, 5, A_ADD,  0, 1, 1, 0,       32'hFFFFFFFF, 3,            0,            32'h55555555, 33));
        tv.push_back(mk(1, 6, A_ADD,  0, 1, 1, 0,       7,            32'hFFFFFFFE, 0,            32'd1,        33));
        tv.push_back(mk(1, 4, A_ADD,  0, 1, 1, 0,       7,            32'hFFFFFFFE, 0,            32'hFFFFFFFD, 33));
        tv.push_back(mk(1, 5, A_ADD,  0, 1, 1, 0,       32'h80000000, 32'hFFFFFFFF, 0,            32'h0,        33));
        add1 = tv[0];

        #1 rstn = 1'b0;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_valid", mvalid, 1'b0);
        chk("rst_res", mres, '0);
        chk("rst_wa", mwa, '0);
        chk("rst_we", mwe, 1'b0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        foreach (tv[i]) run_op(tv[i], 5'(i + 1));

`ifdef RV_EX_MULDIV_EN
        dv = mk(1, 4, A_ADD, 0, 1, 1, 0, 1000, 3, 0, 0, 0);
        @(posedge clk); #1;
        drive(dv, 5'd9);
        repeat (11) @(negedge clk);
        chk("kill_pre_stall", stall, 1'b1);
        kill = 1'b1;
        #1 chk("kill_stall", stall, 1'b0);
        @(posedge clk); #1;
        kill = 1'b0; valid = 1'b0; is_md = 1'b0;
        @(negedge clk);
        chk("post_kill_stall", stall, 1'b0);
        chk("post_kill_valid", mvalid, 1'b0);
        repeat (3) @(negedge clk);
        run_op(add1, 5'd10);

        dv = mk(1, 5, A_ADD, 0, 1, 1, 0, 9, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(dv, 5'd11);
        @(negedge clk);
        chk("done_kill_issue_stall", stall, 1'b1);
        @(negedge clk);
        chk("done_kill_done_stall", stall, 1'b0);
        kill = 1'b1;
        @(posedge clk); #1;
        chk("done_kill_valid", mvalid, 1'b0);
        kill = 1'b0; valid = 1'b0; is_md = 1'b0;

        dv = mk(1, 4, A_ADD, 0, 1, 1, 0, 1000, 3, 0, 0, 0);
        @(posedge clk); #1;
        drive(dv, 5'd12);
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_valid", mvalid, 1'b0);
        chk("mid_rst_res", mres, '0);
        chk("mid_rst_wa", mwa, '0);
        chk("mid_rst_we", mwe, 1'b0);
        @(posedge clk); #1;
        valid = 1'b0; is_md = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", stall, 1'b0);
        run_op(add1, 5'd13);
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
